// File: rtl/fpu_pkg.sv
// Shared FPU types and widths for the signed-fraction -> sign/magnitude normalizer.
package fpu_pkg;

    localparam int unsigned FRAC_W = 26;
    localparam int unsigned EXP_W  = 8;
    localparam int unsigned LZ_W   = $clog2(FRAC_W + 1);

    typedef logic signed [FRAC_W:0]   frac_s_t;
    typedef logic        [FRAC_W-1:0] frac_u_t;
    typedef logic        [EXP_W-1:0]  exp_t;
    typedef logic        [EXP_W:0]    expx_t;
    typedef logic        [FRAC_W:0]   mag_t;
    typedef logic        [LZ_W-1:0]   lz_t;

    localparam exp_t EXP_MAX = '1;

    // Stage-1 payload: sign split off, magnitude one bit wider so -2^26 stays exact
    typedef struct packed {
        logic sign;
        mag_t mag;
        exp_t exp;
    } s1_t;

    typedef struct packed {
        logic    sign;
        frac_u_t frac;
        exp_t    exp;
        logic    zero;
        logic    ovf;
        logic    unf;
    } res_t;

endpackage

// File: rtl/s_to_u_normalize_if.sv
// Input beat and result channels of the normalizer, each with valid/ready.
interface s_to_u_normalize_if;

    logic             in_valid;
    logic             in_ready;
    fpu_pkg::frac_s_t frac_signed;
    fpu_pkg::exp_t    exp_in;

    logic             out_valid;
    logic             out_ready;
    logic             sign;
    fpu_pkg::frac_u_t frac_unsigned;
    fpu_pkg::exp_t    exp_out;
    logic             zero;
    logic             ovf;
    logic             unf;

    modport slave (
        input  in_valid, frac_signed, exp_in, out_ready,
        output in_ready, out_valid, sign, frac_unsigned, exp_out, zero, ovf, unf
    );

    modport master (
        output in_valid, frac_signed, exp_in, out_ready,
        input  in_ready, out_valid, sign, frac_unsigned, exp_out, zero, ovf, unf
    );

endinterface

// File: rtl/s_to_u_normalize_lzc.sv
// Combinational leading-zero counter; an all-zero input returns W.
module s_to_u_normalize_lzc
    import fpu_pkg::*;
#(
    parameter int unsigned W  = FRAC_W,
    parameter int unsigned CW = LZ_W
) (
    input  logic [W-1:0]  din,
    output logic [CW-1:0] count_c
);

    // Scan upward so the highest set bit wins
    always_comb begin
        count_c = CW'(W);
        for (int i = 0; i < int'(W); i++) begin
            if (din[i]) begin
                count_c = CW'(W - 1 - i);
            end
        end
    end

endmodule

// File: rtl/s_to_u_normalize.sv
// Two-stage valid/ready normalizer: signed fraction -> sign, normalized magnitude, exponent.
// Build option FPU_SUBNORMAL_EN: keep denormal results on underflow instead of flushing to zero.
module s_to_u_normalize
    import fpu_pkg::*;
(
    input  logic              CLK,
    input  logic              nRST,
    s_to_u_normalize_if.slave bus
);

    logic  s1_valid_q, s1_valid_d;
    logic  s2_valid_q, s2_valid_d;
    s1_t   s1_q, s1_d;
    res_t  res_q, res_d;

    logic  s1_en, s2_en;
    s1_t   cvt;
    res_t  nrm;
    lz_t   lz;
    expx_t exp_x, exp_inc, exp_dec;
    exp_t  sub_shift;

    assign s2_en        = !s2_valid_q || bus.out_ready;
    assign s1_en        = !s1_valid_q || s2_en;
    assign bus.in_ready = s1_en;

    // Stage 1: two's complement -> sign/magnitude
    always_comb begin
        cvt      = '0;
        cvt.sign = bus.frac_signed[FRAC_W];
        cvt.mag  = cvt.sign ? mag_t'(-bus.frac_signed) : mag_t'(bus.frac_signed);
        cvt.exp  = bus.exp_in;
    end

    s_to_u_normalize_lzc #(
        .W  (FRAC_W),
        .CW (LZ_W)
    ) u_lzc (
        .din     (s1_q.mag[FRAC_W-1:0]),
        .count_c (lz)
    );

    // Stage 2: exponent math one bit wide so carry/borrow are visible
    always_comb begin
        nrm       = '0;
        nrm.sign  = s1_q.sign;
        sub_shift = '0;
        exp_x     = {1'b0, s1_q.exp};
        exp_inc   = exp_x + expx_t'(1);
        exp_dec   = exp_x - expx_t'(lz);
        if (s1_q.mag[FRAC_W]) begin
            if (exp_inc >= expx_t'(EXP_MAX)) begin
                nrm.exp = EXP_MAX;
                nrm.ovf = 1'b1;
            end else begin
                nrm.frac = s1_q.mag[FRAC_W:1];
                nrm.exp  = exp_inc[EXP_W-1:0];
            end
        end else if (s1_q.mag == '0) begin
            nrm.sign = 1'b0;
            nrm.zero = 1'b1;
        end else if (!exp_dec[EXP_W] && (exp_dec != '0)) begin
            nrm.frac = s1_q.mag[FRAC_W-1:0] << lz;
            nrm.exp  = exp_dec[EXP_W-1:0];
        end else begin
`ifdef FPU_SUBNORMAL_EN
            sub_shift = (s1_q.exp == '0) ? '0 : s1_q.exp - exp_t'(1);
            nrm.frac  = s1_q.mag[FRAC_W-1:0] << sub_shift;
            nrm.zero  = (nrm.frac == '0);
            nrm.unf   = 1'b1;
`else
            nrm.zero  = 1'b1;
            nrm.unf   = 1'b1;
`endif
        end
    end

    // Pipeline advance: a stage loads when empty or when its contents move on
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_d       = s1_q;
        s2_valid_d = s2_valid_q;
        res_d      = res_q;
        if (s1_en) begin
            s1_valid_d = bus.in_valid;
            if (bus.in_valid) begin
                s1_d = cvt;
            end
        end
        if (s2_en) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                res_d = nrm;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s1_q       <= '0;
            res_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s1_q       <= s1_d;
            res_q      <= res_d;
        end
    end

    assign bus.out_valid     = s2_valid_q;
    assign bus.sign          = res_q.sign;
    assign bus.frac_unsigned = res_q.frac;
    assign bus.exp_out       = res_q.exp;
    assign bus.zero          = res_q.zero;
    assign bus.ovf           = res_q.ovf;
    assign bus.unf           = res_q.unf;

endmodule
